// File: rtl/cgra_io_model_pkg.sv
// Shared constants and types for the behavioural CGRA array model.
package cgra_io_model_pkg;

    localparam int NUM_PRR             = 16;
    localparam int NUM_GROUPS          = 8;
    localparam int CGRA_PER_GLB        = 2;
    localparam int CGRA_DATA_WIDTH     = 16;
    localparam int CGRA_CFG_ADDR_WIDTH = 32;
    localparam int CGRA_CFG_DATA_WIDTH = 32;
    localparam int CFG_REG_DEPTH       = 16;
    localparam int FIFO_DEPTH          = 4;

    localparam int CFG_IDX_W     = $clog2(CFG_REG_DEPTH);
    localparam int PRR_PER_GROUP = NUM_PRR / NUM_GROUPS;

    localparam int REG_OFFSET = 0;
    localparam int REG_ENABLE = 1;

    typedef struct packed {
        logic                       ctrl;
        logic [CGRA_DATA_WIDTH-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/cgra_prr_model.sv
// One PRR: config register file plus column-0 to column-1 loopback FIFO.
module cgra_prr_model
    import cgra_io_model_pkg::*;
(
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic                                             stall,
    input  logic                                             flush,
    input  logic                                             cfg_wr_en,
    input  logic [CGRA_CFG_ADDR_WIDTH-1:0]                   cfg_wr_addr,
    input  logic [CGRA_CFG_DATA_WIDTH-1:0]                   cfg_wr_data,
    input  logic                                             cfg_rd_en,
    input  logic [CGRA_CFG_ADDR_WIDTH-1:0]                   cfg_rd_addr,
    output logic [CGRA_CFG_DATA_WIDTH-1:0]                   cfg_rd_data,
    input  logic [CGRA_PER_GLB-1:0]                          io1_g2io,
    input  logic [CGRA_PER_GLB-1:0][CGRA_DATA_WIDTH-1:0]     io16_g2io,
    input  logic [CGRA_PER_GLB-1:0]                          io16_g2io_vld,
    output logic [CGRA_PER_GLB-1:0]                          io16_g2io_rdy,
    output logic [CGRA_PER_GLB-1:0]                          io1_io2g,
    output logic [CGRA_PER_GLB-1:0][CGRA_DATA_WIDTH-1:0]     io16_io2g,
    output logic [CGRA_PER_GLB-1:0]                          io16_io2g_vld,
    input  logic [CGRA_PER_GLB-1:0]                          io16_io2g_rdy
);

    localparam int PW = $clog2(FIFO_DEPTH);

    logic [CGRA_CFG_DATA_WIDTH-1:0] regs [CFG_REG_DEPTH];
    logic [CFG_IDX_W-1:0]           wr_idx;
    logic [CFG_IDX_W-1:0]           rd_idx;

    assign wr_idx = cfg_wr_addr[CFG_IDX_W-1:0];
    assign rd_idx = cfg_rd_addr[CFG_IDX_W-1:0];

    // Read samples the pre-write value, so same-index RW returns old data.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < CFG_REG_DEPTH; k++) regs[k] <= '0;
            cfg_rd_data <= '0;
        end else begin
            if (cfg_wr_en) regs[wr_idx] <= cfg_wr_data;
            if (cfg_rd_en) cfg_rd_data <= regs[rd_idx];
        end
    end

    logic                       enable;
    logic [CGRA_DATA_WIDTH-1:0] offset;
    logic                       active;

    assign enable = regs[REG_ENABLE][0];
    assign offset = regs[REG_OFFSET][CGRA_DATA_WIDTH-1:0];
    assign active = enable & ~stall;

    fifo_entry_t mem [FIFO_DEPTH];
    fifo_entry_t head;
    fifo_entry_t in_entry;
    logic [PW:0] wptr;
    logic [PW:0] rptr;
    logic        empty;
    logic        full;
    logic        push;
    logic        pop;

    assign empty    = (wptr == rptr);
    assign full     = (wptr[PW] != rptr[PW]) &&
                      (wptr[PW-1:0] == rptr[PW-1:0]);
    assign head     = mem[rptr[PW-1:0]];
    assign in_entry = '{ctrl: io1_g2io[0], data: io16_g2io[0]};
    assign push     = io16_g2io_vld[0] & active & ~full;
    assign pop      = io16_io2g_rdy[1] & active & ~empty;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[PW-1:0]] <= in_entry;
    end

    always_comb begin
        io16_g2io_rdy    = '0;
        io16_io2g_vld    = '0;
        io1_io2g         = '0;
        io16_io2g        = '0;
        io16_g2io_rdy[0] = active & ~full;
        io16_io2g_vld[1] = active & ~empty;
        if (!empty) begin
            io1_io2g[1]  = head.ctrl;
            io16_io2g[1] = head.data + offset;
        end
    end

    // Column 1 input, column 0 return and upper address bits are don't-cares.
    logic unused_inputs;
    assign unused_inputs = ^{io1_g2io[1], io16_g2io[1], io16_g2io_vld[1],
                             io16_io2g_rdy[0],
                             cfg_wr_addr[CGRA_CFG_ADDR_WIDTH-1:CFG_IDX_W],
                             cfg_rd_addr[CGRA_CFG_ADDR_WIDTH-1:CFG_IDX_W]};

endmodule

// File: rtl/cgra_io_model.sv
// Behavioural CGRA array: one loopback PRR per GLB tile, grouped for flush.
module cgra_io_model
    import cgra_io_model_pkg::*;
(
    input  logic                                                    clk,
    input  logic                                                    reset,
    input  logic [NUM_PRR-1:0]                                      stall,
    input  logic [NUM_GROUPS-1:0]                                   strm_data_flush_g2f,
    input  logic [NUM_PRR-1:0]                                      cfg_wr_en,
    input  logic [NUM_PRR-1:0][CGRA_CFG_ADDR_WIDTH-1:0]             cfg_wr_addr,
    input  logic [NUM_PRR-1:0][CGRA_CFG_DATA_WIDTH-1:0]             cfg_wr_data,
    input  logic [NUM_PRR-1:0]                                      cfg_rd_en,
    input  logic [NUM_PRR-1:0][CGRA_CFG_ADDR_WIDTH-1:0]             cfg_rd_addr,
    output logic [NUM_PRR-1:0][CGRA_CFG_DATA_WIDTH-1:0]             cfg_rd_data,
    input  logic [NUM_PRR-1:0][CGRA_PER_GLB-1:0]                    io1_g2io,
    input  logic [NUM_PRR-1:0][CGRA_PER_GLB-1:0][CGRA_DATA_WIDTH-1:0] io16_g2io,
    input  logic [NUM_PRR-1:0][CGRA_PER_GLB-1:0]                    io16_g2io_vld,
    output logic [NUM_PRR-1:0][CGRA_PER_GLB-1:0]                    io16_g2io_rdy,
    output logic [NUM_PRR-1:0][CGRA_PER_GLB-1:0]                    io1_io2g,
    output logic [NUM_PRR-1:0][CGRA_PER_GLB-1:0][CGRA_DATA_WIDTH-1:0] io16_io2g,
    output logic [NUM_PRR-1:0][CGRA_PER_GLB-1:0]                    io16_io2g_vld,
    input  logic [NUM_PRR-1:0][CGRA_PER_GLB-1:0]                    io16_io2g_rdy
);

    for (genvar i = 0; i < NUM_PRR; i++) begin : g_prr
        localparam int G = i / PRR_PER_GROUP;

        cgra_prr_model u_prr (
            .clk           (clk),
            .reset         (reset),
            .stall         (stall[i]),
            .flush         (strm_data_flush_g2f[G]),
            .cfg_wr_en     (cfg_wr_en[i]),
            .cfg_wr_addr   (cfg_wr_addr[i]),
            .cfg_wr_data   (cfg_wr_data[i]),
            .cfg_rd_en     (cfg_rd_en[i]),
            .cfg_rd_addr   (cfg_rd_addr[i]),
            .cfg_rd_data   (cfg_rd_data[i]),
            .io1_g2io      (io1_g2io[i]),
            .io16_g2io     (io16_g2io[i]),
            .io16_g2io_vld (io16_g2io_vld[i]),
            .io16_g2io_rdy (io16_g2io_rdy[i]),
            .io1_io2g      (io1_io2g[i]),
            .io16_io2g     (io16_io2g[i]),
            .io16_io2g_vld (io16_io2g_vld[i]),
            .io16_io2g_rdy (io16_io2g_rdy[i])
        );
    end

endmodule

// File: tb/tb_cgra_io_model.sv
// Directed self-checking bench for cgra_io_model.
module tb_cgra_io_model;
    import cgra_io_model_pkg::*;

    logic clk;
    logic reset;
    logic [NUM_PRR-1:0]                                        stall;
    logic [NUM_GROUPS-1:0]                                     strm_data_flush_g2f;
    logic [NUM_PRR-1:0]                                        cfg_wr_en;
    logic [NUM_PRR-1:0][CGRA_CFG_ADDR_WIDTH-1:0]               cfg_wr_addr;
    logic [NUM_PRR-1:0][CGRA_CFG_DATA_WIDTH-1:0]               cfg_wr_data;
    logic [NUM_PRR-1:0]                                        cfg_rd_en;
    logic [NUM_PRR-1:0][CGRA_CFG_ADDR_WIDTH-1:0]               cfg_rd_addr;
    logic [NUM_PRR-1:0][CGRA_CFG_DATA_WIDTH-1:0]               cfg_rd_data;
    logic [NUM_PRR-1:0][CGRA_PER_GLB-1:0]                      io1_g2io;
    logic [NUM_PRR-1:0][CGRA_PER_GLB-1:0][CGRA_DATA_WIDTH-1:0] io16_g2io;
    logic [NUM_PRR-1:0][CGRA_PER_GLB-1:0]                      io16_g2io_vld;
    logic [NUM_PRR-1:0][CGRA_PER_GLB-1:0]                      io16_g2io_rdy;
    logic [NUM_PRR-1:0][CGRA_PER_GLB-1:0]                      io1_io2g;
    logic [NUM_PRR-1:0][CGRA_PER_GLB-1:0][CGRA_DATA_WIDTH-1:0] io16_io2g;
    logic [NUM_PRR-1:0][CGRA_PER_GLB-1:0]                      io16_io2g_vld;
    logic [NUM_PRR-1:0][CGRA_PER_GLB-1:0]                      io16_io2g_rdy;

    int n_pass;
    int n_total;
    logic [31:0] rd;

    cgra_io_model dut (
        .clk                 (clk),
        .reset               (reset),
        .stall               (stall),
        .strm_data_flush_g2f (strm_data_flush_g2f),
        .cfg_wr_en           (cfg_wr_en),
        .cfg_wr_addr         (cfg_wr_addr),
        .cfg_wr_data         (cfg_wr_data),
        .cfg_rd_en           (cfg_rd_en),
        .cfg_rd_addr         (cfg_rd_addr),
        .cfg_rd_data         (cfg_rd_data),
        .io1_g2io            (io1_g2io),
        .io16_g2io           (io16_g2io),
        .io16_g2io_vld       (io16_g2io_vld),
        .io16_g2io_rdy       (io16_g2io_rdy),
        .io1_io2g            (io1_io2g),
        .io16_io2g           (io16_io2g),
        .io16_io2g_vld       (io16_io2g_vld),
        .io16_io2g_rdy       (io16_io2g_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int p, input logic [31:0] a,
                             input logic [31:0] d);
        cfg_wr_en[p]   = 1'b1;
        cfg_wr_addr[p] = a;
        cfg_wr_data[p] = d;
        tick();
        cfg_wr_en[p]   = 1'b0;
    endtask

    task automatic cfg_read(input int p, input logic [31:0] a,
                            output logic [31:0] d);
        cfg_rd_en[p]   = 1'b1;
        cfg_rd_addr[p] = a;
        tick();
        cfg_rd_en[p]   = 1'b0;
        d = cfg_rd_data[p];
    endtask

    task automatic push(input int p, input logic [15:0] d);
        io16_g2io_vld[p][0] = 1'b1;
        io16_g2io[p][0]     = d;
        io1_g2io[p][0]      = 1'b0;
        tick();
        io16_g2io_vld[p][0] = 1'b0;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        reset = 1'b1;
        stall = '0;
        strm_data_flush_g2f = '0;
        cfg_wr_en = '0;
        cfg_wr_addr = '0;
        cfg_wr_data = '0;
        cfg_rd_en = '0;
        cfg_rd_addr = '0;
        io1_g2io = '0;
        io16_g2io = '0;
        io16_g2io_vld = '0;
        io16_io2g_rdy = '0;
        repeat (3) tick();
        reset = 1'b0;
        #1;

        // reset state
        check("rst_vld", 32'(io16_io2g_vld), 32'h0);
        check("rst_rdy", 32'(io16_g2io_rdy), 32'h0);
        cfg_read(3, 32'd0, rd);
        check("rst_reg0", rd, 32'h0);
        cfg_read(3, 32'd1, rd);
        check("rst_reg1", rd, 32'h0);

        // basic stream with offset 0x10
        cfg_write(0, 32'd0, 32'h0010);
        cfg_write(0, 32'd1, 32'h1);
        io16_io2g_rdy[0][1] = 1'b1;
        #1;
        check("en_rdy0", 32'(io16_g2io_rdy[0][0]), 32'h1);
        check("col1_rdy", 32'(io16_g2io_rdy[0][1]), 32'h0);
        check("empty_vld", 32'(io16_io2g_vld[0][1]), 32'h0);
        io16_g2io_vld[0][0] = 1'b1;
        io16_g2io[0][0] = 16'h0001;
        io1_g2io[0][0] = 1'b0;
        tick();
        check("s1_vld", 32'(io16_io2g_vld[0][1]), 32'h1);
        check("s1_data", 32'(io16_io2g[0][1]), 32'h0011);
        check("s1_io1", 32'(io1_io2g[0][1]), 32'h0);
        check("col0_vld", 32'(io16_io2g_vld[0][0]), 32'h0);
        check("col0_data", 32'(io16_io2g[0][0]), 32'h0);
        io16_g2io[0][0] = 16'h0002;
        tick();
        check("s2_data", 32'(io16_io2g[0][1]), 32'h0012);
        check("s2_io1", 32'(io1_io2g[0][1]), 32'h0);
        io16_g2io[0][0] = 16'h0003;
        io1_g2io[0][0] = 1'b1;
        tick();
        check("s3_data", 32'(io16_io2g[0][1]), 32'h0013);
        check("s3_io1", 32'(io1_io2g[0][1]), 32'h1);
        io16_g2io_vld[0][0] = 1'b0;
        io1_g2io[0][0] = 1'b0;
        tick();
        check("s4_vld", 32'(io16_io2g_vld[0][1]), 32'h0);
        check("s4_data", 32'(io16_io2g[0][1]), 32'h0);
        check("s4_io1", 32'(io1_io2g[0][1]), 32'h0);

        // offset wrap, written through an aliased address
        cfg_write(0, 32'h0000_0010, 32'h0000_FFFF);
        cfg_read(0, 32'd0, rd);
        check("alias_reg0", rd, 32'h0000_FFFF);
        push(0, 16'h0002);
        check("wrap_data", 32'(io16_io2g[0][1]), 32'h0001);
        tick();
        check("wrap_drain", 32'(io16_io2g_vld[0][1]), 32'h0);

        // backpressure: 4 of 5 accepted
        cfg_write(0, 32'd0, 32'h0);
        io16_io2g_rdy[0][1] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            io16_g2io_vld[0][0] = 1'b1;
            io16_g2io[0][0] = 16'(16'hA0 + k);
            #1;
            check("fill_rdy", 32'(io16_g2io_rdy[0][0]), (k < 4) ? 32'h1 : 32'h0);
            tick();
        end
        io16_g2io[0][0] = 16'h00BB;
        io16_io2g_rdy[0][1] = 1'b1;
        #1;
        check("full_pop_rdy", 32'(io16_g2io_rdy[0][0]), 32'h0);
        check("drain0", 32'(io16_io2g[0][1]), 32'h00A0);
        tick();
        io16_g2io_vld[0][0] = 1'b0;
        for (int k = 1; k < 4; k++) begin
            check("drain_vld", 32'(io16_io2g_vld[0][1]), 32'h1);
            check("drain_data", 32'(io16_io2g[0][1]), 32'(16'hA0 + k));
            tick();
        end
        check("drain_end", 32'(io16_io2g_vld[0][1]), 32'h0);
        io16_io2g_rdy[0][1] = 1'b0;

        // group flush
        cfg_write(1, 32'd1, 32'h1);
        cfg_write(2, 32'd1, 32'h1);
        for (int p = 0; p < 3; p++) begin
            io16_g2io_vld[p][0] = 1'b1;
            io16_g2io[p][0] = 16'(16'h30 + p);
        end
        tick();
        for (int p = 0; p < 3; p++) io16_g2io_vld[p][0] = 1'b0;
        check("pre_fl_p0", 32'(io16_io2g_vld[0][1]), 32'h1);
        check("pre_fl_p1", 32'(io16_io2g_vld[1][1]), 32'h1);
        strm_data_flush_g2f[0] = 1'b1;
        tick();
        strm_data_flush_g2f[0] = 1'b0;
        check("fl_p0", 32'(io16_io2g_vld[0][1]), 32'h0);
        check("fl_p1", 32'(io16_io2g_vld[1][1]), 32'h0);
        check("fl_p2_vld", 32'(io16_io2g_vld[2][1]), 32'h1);
        check("fl_p2_data", 32'(io16_io2g[2][1]), 32'h0032);
        io16_io2g_rdy[2][1] = 1'b1;
        tick();
        io16_io2g_rdy[2][1] = 1'b0;

        // stall holds contents; config still works
        push(0, 16'h0041);
        push(0, 16'h0042);
        stall[0] = 1'b1;
        io16_io2g_rdy[0][1] = 1'b1;
        io16_g2io_vld[0][0] = 1'b1;
        io16_g2io[0][0] = 16'h0099;
        #1;
        check("stall_rdy", 32'(io16_g2io_rdy[0][0]), 32'h0);
        check("stall_vld", 32'(io16_io2g_vld[0][1]), 32'h0);
        tick();
        tick();
        cfg_write(0, 32'd2, 32'h0000_CAFE);
        cfg_read(0, 32'd2, rd);
        check("stall_cfg", rd, 32'h0000_CAFE);
        cfg_wr_en[0] = 1'b1;
        cfg_wr_addr[0] = 32'd2;
        cfg_wr_data[0] = 32'h0000_1111;
        cfg_rd_en[0] = 1'b1;
        cfg_rd_addr[0] = 32'd2;
        tick();
        cfg_wr_en[0] = 1'b0;
        cfg_rd_en[0] = 1'b0;
        check("rw_old", 32'(cfg_rd_data[0]), 32'h0000_CAFE);
        cfg_read(0, 32'd2, rd);
        check("rw_new", rd, 32'h0000_1111);
        io16_g2io_vld[0][0] = 1'b0;
        stall[0] = 1'b0;
        #1;
        check("resume_vld", 32'(io16_io2g_vld[0][1]), 32'h1);
        check("resume_d0", 32'(io16_io2g[0][1]), 32'h0041);
        tick();
        check("resume_d1", 32'(io16_io2g[0][1]), 32'h0042);
        tick();
        check("resume_end", 32'(io16_io2g_vld[0][1]), 32'h0);
        io16_io2g_rdy[0][1] = 1'b0;

        // reset mid-stream drops FIFO and config
        push(0, 16'h0055);
        check("pre_rst_vld", 32'(io16_io2g_vld[0][1]), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cfg_write(0, 32'd1, 32'h1);
        check("post_rst_vld", 32'(io16_io2g_vld[0][1]), 32'h0);
        cfg_read(0, 32'd2, rd);
        check("post_rst_reg2", rd, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cgra_io_model.md
Name: cgra_io_model

Overview:
- Behavioural CGRA array model. Sits below the global buffer in the GLB system bench and stands in for the real CGRA fabric.
- One partial-reconfiguration region (PRR) per GLB tile.
- Each PRR holds a small config register file, reachable through the GLB config path.
- Each PRR loops streaming data from its g2io column 0 back out on its io2g column 1, through a FIFO with a configurable data offset.

Parameters:
- NUM_PRR, 16, number of PRRs (equals number of GLB tiles)
- NUM_GROUPS, 8, flush groups; PRR i belongs to group i/(NUM_PRR/NUM_GROUPS)
- CGRA_PER_GLB, 2, IO columns per PRR
- CGRA_DATA_WIDTH, 16, streaming data width
- CGRA_CFG_ADDR_WIDTH, 32, config address width
- CGRA_CFG_DATA_WIDTH, 32, config data width
- CFG_REG_DEPTH, 16, config registers per PRR (power of 2)
- FIFO_DEPTH, 4, loopback FIFO entries per PRR (power of 2, >=2)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- stall  in  NUM_PRR  per-PRR datapath stall
- strm_data_flush_g2f  in  NUM_GROUPS  per-group flush pulse
- cfg_wr_en  in  NUM_PRR  config write enable
- cfg_wr_addr  in  NUM_PRR x CGRA_CFG_ADDR_WIDTH  config write address
- cfg_wr_data  in  NUM_PRR x CGRA_CFG_DATA_WIDTH  config write data
- cfg_rd_en  in  NUM_PRR  config read enable
- cfg_rd_addr  in  NUM_PRR x CGRA_CFG_ADDR_WIDTH  config read address
- cfg_rd_data  out  NUM_PRR x CGRA_CFG_DATA_WIDTH  config read data
- io1_g2io  in  NUM_PRR x CGRA_PER_GLB  1-bit control from GLB
- io16_g2io  in  NUM_PRR x CGRA_PER_GLB x 16  data from GLB
- io16_g2io_vld  in  NUM_PRR x CGRA_PER_GLB  valid from GLB
- io16_g2io_rdy  out  NUM_PRR x CGRA_PER_GLB  ready to GLB
- io1_io2g  out  NUM_PRR x CGRA_PER_GLB  1-bit control to GLB
- io16_io2g  out  NUM_PRR x CGRA_PER_GLB x 16  data to GLB
- io16_io2g_vld  out  NUM_PRR x CGRA_PER_GLB  valid to GLB
- io16_io2g_rdy  in  NUM_PRR x CGRA_PER_GLB  ready from GLB

Behaviour:
- All state is on the rising edge of clk. Reset clears the config registers, the FIFOs (empty) and cfg_rd_data to 0.

Config path, per PRR i:
- Register index is cfg_*_addr[i][log2(CFG_REG_DEPTH)-1:0]. Upper address bits are ignored, so addresses alias.
- Write: on cfg_wr_en[i], reg[idx] <= cfg_wr_data[i].
- Read: on cfg_rd_en[i], cfg_rd_data[i] <= reg[idx], giving 1-cycle latency. cfg_rd_data holds its value when cfg_rd_en is low.
- Simultaneous read and write to the same index returns the old value.
- reg0[15:0] is OFFSET. reg1[0] is ENABLE. Other registers are scratch.

Datapath, per PRR i:
- Column 0 input feeds the FIFO. Entry = {io1_g2io[i][0], io16_g2io[i][0]}.
- io16_g2io_rdy[i][0] = ENABLE & ~stall[i] & ~full.
- Push when vld & rdy.
- Column 1 output:
  - io16_io2g_vld[i][1] = ENABLE & ~stall[i] & ~empty.
  - io16_io2g[i][1] = head data + OFFSET, mod 2^16 (wraps).
  - io1_io2g[i][1] = head ctrl bit.
  - Pop when vld & io16_io2g_rdy[i][1].
- Push and pop in the same cycle are allowed, including when the FIFO is full-side or empty-side, subject to the rdy/vld rules above. A full FIFO does not accept a push even if a pop happens the same cycle.
- Column 1 input: rdy = 0, input ignored.
- Column 0 output: vld, data and io1 are all 0.
- Data and ctrl outputs are 0 when empty.
- Flush: strm_data_flush_g2f[g] empties the FIFOs of all PRRs in group g next cycle. Flush overrides push/pop in that cycle. Config registers are unaffected.
- Stall freezes FIFO contents. Config access is still honoured during stall.
- Reset mid-stream drops all FIFO contents.

Decomposition:
- Shared package: NUM_PRR, NUM_GROUPS, CGRA_PER_GLB, data/config widths, OFFSET/ENABLE register indices.
- One sub-module, cgra_prr_model: one PRR's regfile, FIFO and IO mapping, instantiated NUM_PRR times with its group flush bit.

Test Plan:
- Reset, then read reg0 and reg1 of PRR 3 -> cfg_rd_data[3] = 0 one cycle after cfg_rd_en; all io16_io2g_vld = 0 and io16_g2io_rdy = 0.
- Write reg0 = 0x0010 and reg1 = 1 on PRR 0; stream 1, 2, 3 with io1 = 1 on the last word; rdy held high -> column 1 outputs 0x11, 0x12, 0x13 in order, io1 = 1 on 0x13 only.
- Write 0xFFFF to OFFSET, send 0x0002 -> output 0x0001 (wrap).
- Hold io16_io2g_rdy low, push 5 words -> 4 accepted, rdy[0] drops on the 5th; release -> 4 words drained, none lost or duplicated.
- Fill PRR 0 and PRR 1 (group 0), pulse strm_data_flush_g2f[0] -> both FIFOs empty next cycle; PRR 2 FIFO unchanged.
- Assert stall[0] mid-stream -> rdy and vld low and contents held; deassert -> stream resumes in order. Config write and read during stall succeed.
